// File: rtl/video_pattern_gen_if.sv
// Pixel bus carried from the pattern source into the video pipeline:
// data enable, sync pulses and one CW-bit value per colour channel.
interface video_pattern_gen_if #(
  parameter int CW = 8
);
  logic          hdmi_de;
  logic          hdmi_hs;
  logic          hdmi_vs;
  logic [CW-1:0] hdmi_r;
  logic [CW-1:0] hdmi_g;
  logic [CW-1:0] hdmi_b;

  modport master (
    output hdmi_de, hdmi_hs, hdmi_vs, hdmi_r, hdmi_g, hdmi_b
  );

  modport slave (
    input hdmi_de, hdmi_hs, hdmi_vs, hdmi_r, hdmi_g, hdmi_b
  );
endinterface

// File: rtl/video_pattern_gen.sv
// Parametrised raster timing generator with selectable RGB test patterns.
// The h/v counters form stage p0. Every output is registered once from the
// counter state, in stage p1.
module video_pattern_gen #(
  parameter int HR       = 800,
  parameter int HFP      = 8,
  parameter int HS       = 2,
  parameter int HBP      = 8,
  parameter int VR       = 300,
  parameter int VFP      = 8,
  parameter int VS       = 4,
  parameter int VBP      = 8,
  parameter int CW       = 8,
  parameter int CHK_LOG2 = 3,
  parameter bit SYNC_POL = 1'b1
) (
  input  logic                   hdmi_clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic                   scroll,
  input  logic [3*CW-1:0]        solid_rgb,
  video_pattern_gen_if.master    hdmi,
  output logic                   frame_start,
  output logic [15:0]            frame_cnt
);
  localparam int HT  = HR + HFP + HS + HBP;
  localparam int VT  = VR + VFP + VS + VBP;
  localparam int HW  = $clog2(HT);
  localparam int VW  = $clog2(VT);
  localparam int BW  = (HR >= 8) ? HR / 8 : 1;
  localparam int BCW = (BW > 1) ? $clog2(BW) : 1;

  localparam logic [HW-1:0]  H_LAST   = HW'(HT - 1);
  localparam logic [HW-1:0]  H_ACT    = HW'(HR);
  localparam logic [HW-1:0]  HS_BEG   = HW'(HR + HFP);
  localparam logic [HW-1:0]  HS_LAST  = HW'(HR + HFP + HS - 1);
  localparam logic [VW-1:0]  V_LAST   = VW'(VT - 1);
  localparam logic [VW-1:0]  V_ACT    = VW'(VR);
  localparam logic [VW-1:0]  VS_BEG   = VW'(VR + VFP);
  localparam logic [VW-1:0]  VS_LAST  = VW'(VR + VFP + VS - 1);
  localparam logic [BCW-1:0] B_LAST   = BCW'(BW - 1);

  logic [HW-1:0]   h_p0;
  logic [VW-1:0]   v_p0;
  logic [BCW-1:0]  bar_cnt_p0;
  logic [2:0]      bar_idx_p0;

  logic [1:0]      mode_q;
  logic            scroll_q;
  logic [3*CW-1:0] solid_q;

  logic            at_origin, h_wrap, v_wrap;
  logic            de_p0, hs_p0, vs_p0;
  logic [1:0]      mode_eff;
  logic            scroll_eff;
  logic [3*CW-1:0] solid_eff;
  logic [HW-1:0]   hx;
  logic [3*CW-1:0] rgb_p0;

  logic            de_p1, hs_p1, vs_p1, fs_p1;
  logic [3*CW-1:0] rgb_p1;

  // Bars in index order: white, yellow, cyan, green, magenta, red, blue, black.
  // Red is lit for indices 0,1,4,5; green for 0..3; blue for even indices.
  function automatic logic [3*CW-1:0] bar_color(input logic [2:0] idx);
    logic [CW-1:0] r, g, b;
    r = idx[1] ? '0 : '1;
    g = idx[2] ? '0 : '1;
    b = idx[0] ? '0 : '1;
    return {r, g, b};
  endfunction

  // Map an in-window flag to the pin level for the chosen polarity.
  function automatic logic sync_level(input logic active);
    return active ? SYNC_POL : ~SYNC_POL;
  endfunction

  // Decode the counter state and select this pixel's pattern value.
  always_comb begin
    at_origin  = (h_p0 == '0) && (v_p0 == '0);
    h_wrap     = (h_p0 == H_LAST);
    v_wrap     = (v_p0 == V_LAST);
    de_p0      = (h_p0 < H_ACT) && (v_p0 < V_ACT);
    hs_p0      = (h_p0 >= HS_BEG) && (h_p0 <= HS_LAST);
    vs_p0      = (v_p0 >= VS_BEG) && (v_p0 <= VS_LAST);
    // The origin pixel already belongs to the new frame, so it sees the live
    // selection; every later pixel uses the value latched at the origin.
    mode_eff   = at_origin ? mode      : mode_q;
    scroll_eff = at_origin ? scroll    : scroll_q;
    solid_eff  = at_origin ? solid_rgb : solid_q;
    hx         = h_p0 + (scroll_eff ? HW'(frame_cnt) : '0);
    rgb_p0     = '0;
    if (de_p0) begin
      case (mode_eff)
        2'd0:    rgb_p0 = bar_color(bar_idx_p0);
        2'd1:    rgb_p0 = {3{CW'(h_p0)}};
        2'd2:    rgb_p0 = (hx[CHK_LOG2] ^ v_p0[CHK_LOG2]) ? '1 : '0;
        default: rgb_p0 = solid_eff;
      endcase
    end
  end

  // Raster counters plus a bar tracker that follows h without a divider;
  // an idle generator parks at the start of vertical blanking.
  always_ff @(posedge hdmi_clk) begin
    if (rst || !en) begin
      h_p0       <= '0;
      v_p0       <= V_ACT;
      bar_cnt_p0 <= '0;
      bar_idx_p0 <= '0;
    end else if (h_wrap) begin
      h_p0       <= '0;
      v_p0       <= v_wrap ? '0 : v_p0 + 1'b1;
      bar_cnt_p0 <= '0;
      bar_idx_p0 <= '0;
    end else begin
      h_p0 <= h_p0 + 1'b1;
      if (bar_cnt_p0 == B_LAST) begin
        bar_cnt_p0 <= '0;
        if (bar_idx_p0 != 3'd7) bar_idx_p0 <= bar_idx_p0 + 1'b1;
      end else begin
        bar_cnt_p0 <= bar_cnt_p0 + 1'b1;
      end
    end
  end

  // Count frames completed on the wrap from the last blanking pixel to the origin.
  always_ff @(posedge hdmi_clk) begin
    if (rst) frame_cnt <= '0;
    else if (en && h_wrap && v_wrap) frame_cnt <= frame_cnt + 16'd1;
  end

  // Latch the pattern selection at frame origin so mid-frame changes wait a frame.
  always_ff @(posedge hdmi_clk) begin
    if (rst || at_origin) begin
      mode_q   <= mode;
      scroll_q <= scroll;
      solid_q  <= solid_rgb;
    end
  end

  // Register all outputs one clock behind the counter state; idle when stopped.
  always_ff @(posedge hdmi_clk) begin
    if (rst || !en) begin
      de_p1  <= 1'b0;
      hs_p1  <= sync_level(1'b0);
      vs_p1  <= sync_level(1'b0);
      fs_p1  <= 1'b0;
      rgb_p1 <= '0;
    end else begin
      de_p1  <= de_p0;
      hs_p1  <= sync_level(hs_p0);
      vs_p1  <= sync_level(vs_p0);
      fs_p1  <= at_origin;
      rgb_p1 <= rgb_p0;
    end
  end

  assign hdmi.hdmi_de = de_p1;
  assign hdmi.hdmi_hs = hs_p1;
  assign hdmi.hdmi_vs = vs_p1;
  assign hdmi.hdmi_r  = rgb_p1[3*CW-1:2*CW];
  assign hdmi.hdmi_g  = rgb_p1[2*CW-1:CW];
  assign hdmi.hdmi_b  = rgb_p1[CW-1:0];
  assign frame_start  = fs_p1;
endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen on a small 22x8 raster.
// A reference model predicts every output cycle; directed checks pin the
// key timing numbers and a few pixel values to fixed constants.
module tb_video_pattern_gen;
  localparam int HR = 16, HFP = 2, HS = 2, HBP = 2;
  localparam int VR = 4,  VFP = 1, VS = 2, VBP = 1;
  localparam int CW = 8,  CHK = 1;
  localparam int HT = HR + HFP + HS + HBP;
  localparam int VT = VR + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  logic        hdmi_clk = 1'b0;
  logic        rst, en, scroll;
  logic [1:0]  mode;
  logic [23:0] solid_rgb;
  logic        frame_start;
  logic [15:0] frame_cnt;

  video_pattern_gen_if #(.CW(CW)) vif ();

  video_pattern_gen #(
    .HR(HR), .HFP(HFP), .HS(HS), .HBP(HBP),
    .VR(VR), .VFP(VFP), .VS(VS), .VBP(VBP),
    .CW(CW), .CHK_LOG2(CHK), .SYNC_POL(1'b1)
  ) dut (
    .hdmi_clk    (hdmi_clk),
    .rst         (rst),
    .en          (en),
    .mode        (mode),
    .scroll      (scroll),
    .solid_rgb   (solid_rgb),
    .hdmi        (vif),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  always #5 hdmi_clk = ~hdmi_clk;

  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
    logic        fs;
    logic [15:0] fc;
  } out_t;

  typedef struct {
    out_t o;
    int   x;
    int   y;
    int   m;
    bit   sc;
    int   fc;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  int          mh, mv, mfc, mm;
  bit          msc;
  logic [23:0] msol;

  bit          meas_de, steady, fs_armed, en_chk;
  int          lat, per, hs_n, vs_n, sw_phase;
  logic [15:0] prev_fc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] bar_ref(input int x);
    int i;
    i = x / (HR / 8);
    if (i > 7) i = 7;
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  // Predict the output registered at the next edge and advance the model.
  task automatic model_step(output exp_t e);
    bit org, act;
    int hx;
    org = (mh == 0) && (mv == 0);
    if (rst || org) begin
      mm = int'(mode); msc = scroll; msol = solid_rgb;
    end
    e.o = '0; e.x = -1; e.y = mv; e.m = mm; e.sc = msc; e.fc = mfc;
    if (rst) begin
      mh = 0; mv = VR; mfc = 0;
    end else if (!en) begin
      e.o.fc = 16'(mfc);
      mh = 0; mv = VR;
    end else begin
      act    = (mh < HR) && (mv < VR);
      e.o.de = act;
      e.o.hs = (mh >= HR + HFP) && (mh < HR + HFP + HS);
      e.o.vs = (mv >= VR + VFP) && (mv < VR + VFP + VS);
      e.o.fs = org;
      if (act) begin
        e.x = mh;
        case (mm)
          0: e.o.rgb = bar_ref(mh);
          1: e.o.rgb = {3{8'(mh)}};
          2: begin
            hx = (mh + (msc ? mfc : 0)) % 32;
            e.o.rgb = (((hx >> CHK) ^ (mv >> CHK)) & 1) != 0 ? 24'hFFFFFF : 24'h000000;
          end
          default: e.o.rgb = msol;
        endcase
      end
      if (mh == HT - 1) begin
        mh = 0;
        if (mv == VT - 1) begin mv = 0; mfc = (mfc + 1) % 65536; end
        else mv++;
      end else begin
        mh++;
      end
      e.o.fc = 16'(mfc);
    end
  endtask

  task automatic cycle();
    exp_t e;
    out_t got;
    model_step(e);
    sb_q.push_back(e);
    @(posedge hdmi_clk);
    #1;
    got = {vif.hdmi_de, vif.hdmi_hs, vif.hdmi_vs, vif.hdmi_r, vif.hdmi_g, vif.hdmi_b,
           frame_start, frame_cnt};
    e = sb_q.pop_front();
    check("scoreboard", 64'(got), 64'(e.o));

    if (rst) check("reset_idle", 64'(got), 64'd0);
    if (en_chk) begin
      check("en_off_de_hs_vs", 64'({got.de, got.hs, got.vs}), 64'd0);
      en_chk = 1'b0;
    end

    if (meas_de) begin
      lat++;
      if (got.de) begin
        check("first_de_latency", 64'(lat), 64'd89);
        check("first_de_frame_start", 64'(got.fs), 64'd1);
        meas_de = 1'b0;
      end else if (lat > 400) begin
        check("first_de_timeout", 64'(lat), 64'd89);
        meas_de = 1'b0;
      end
    end

    if (e.o.fs && sw_phase == 1) sw_phase = 2;
    if (e.x >= 0) begin
      if (e.m == 0 && e.y == 0) begin
        if (e.x == 0)  check("bars_px0",  64'(got.rgb), 64'h0000_0000_00FF_FFFF);
        if (e.x == 3)  check("bars_px3",  64'(got.rgb), 64'h0000_0000_00FF_FF00);
        if (e.x == 15) check("bars_px15", 64'(got.rgb), 64'h0);
      end
      if (e.m == 1 && e.x == 5)  check("grad_px5",  64'(got.rgb), 64'h0000_0000_0005_0505);
      if (e.m == 1 && e.x == 15) check("grad_px15", 64'(got.rgb), 64'h0000_0000_000F_0F0F);
      if (e.m == 2 && !e.sc) begin
        if (e.x == 0 && e.y == 0) check("chk_l0_px0", 64'(got.rgb), 64'h0);
        if (e.x == 2 && e.y == 0) check("chk_l0_px2", 64'(got.rgb), 64'h0000_0000_00FF_FFFF);
        if (e.x == 0 && e.y == 2) check("chk_l2_px0", 64'(got.rgb), 64'h0000_0000_00FF_FFFF);
      end
      if (e.m == 2 && e.sc && e.fc == 1 && e.y == 0) begin
        if (e.x == 0) check("scroll_l0_px0", 64'(got.rgb), 64'h0);
        if (e.x == 1) check("scroll_l0_px1", 64'(got.rgb), 64'h0000_0000_00FF_FFFF);
      end
      if (sw_phase == 1 && e.x == 3 && e.y == 2) check("switch_same_frame", 64'(got.rgb), 64'h0000_0000_00FF_FF00);
      if (sw_phase == 2 && e.x == 3 && e.y == 2) check("switch_next_frame", 64'(got.rgb), 64'h0000_0000_0012_3456);
    end

    per++;
    hs_n += int'(got.hs);
    vs_n += int'(got.vs);
    if (!steady) fs_armed = 1'b0;
    if (got.fs) begin
      if (fs_armed) begin
        check("frame_period", 64'(per), 64'(FRAME));
        check("hs_clocks_per_frame", 64'(hs_n), 64'(HS * VT));
        check("vs_clocks_per_frame", 64'(vs_n), 64'(VS * HT));
        check("frame_cnt_step", 64'(got.fc), 64'(16'(prev_fc + 16'd1)));
      end
      fs_armed = steady;
      per = 0; hs_n = 0; vs_n = 0;
      prev_fc = got.fc;
    end
  endtask

  task automatic run_until(input int x, input int y);
    int n;
    n = 0;
    while (!(mh == x && mv == y) && n < 400) begin
      cycle();
      n++;
    end
    check("run_until_reached", 64'((mh == x) && (mv == y)), 64'd1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'd0; scroll = 1'b0; solid_rgb = '0;
    meas_de = 0; steady = 0; fs_armed = 0; en_chk = 0;
    lat = 0; per = 0; hs_n = 0; vs_n = 0; sw_phase = 0; prev_fc = '0;
    mh = 0; mv = VR; mfc = 0; mm = 0; msc = 0; msol = '0;

    @(negedge hdmi_clk);
    repeat (3) cycle();

    rst = 1'b0; meas_de = 1; lat = 0; steady = 1;
    repeat (3 * FRAME) cycle();

    mode = 2'd1;
    repeat (2 * FRAME) cycle();

    mode = 2'd2;
    repeat (2 * FRAME) cycle();

    scroll = 1'b1; rst = 1'b1; steady = 0;
    repeat (2) cycle();
    rst = 1'b0; steady = 1; meas_de = 1; lat = 0;
    repeat (2 * FRAME) cycle();

    scroll = 1'b0; mode = 2'd0;
    repeat (FRAME) cycle();
    run_until(0, 1);
    mode = 2'd3; solid_rgb = 24'h123456; sw_phase = 1;
    repeat (2 * FRAME) cycle();
    sw_phase = 0;

    run_until(7, 1);
    en = 1'b0; steady = 0; en_chk = 1;
    repeat (4) cycle();
    en = 1'b1; steady = 1; meas_de = 1; lat = 0;
    repeat (2 * FRAME) cycle();
    if (meas_de) check("first_de_never_seen", 64'(meas_de), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
